ex_result_stage: RTL and testbench
==================================

# ex_result_stage

Parametrised execute-stage result register. It collects results from NUM_FU functional-unit channels, selects one per cycle by priority, and holds it in a two-entry output buffer (main + skid) with valid/ready handshakes toward writeback. One channel can be designated as a zero-latency bypass, used for load data that arrives late in the cycle. It sits between the EX functional units and the WB stage, and succeeds the fixed six-unit, no-handshake result register.

## Interface
- DATA_W, 32, result width in bits
- NUM_FU, 6, number of functional-unit channels (≥ 2)
- TAG_W, 5, destination-register tag width
- BYPASS_CH, 4, index of the zero-latency channel; -1 disables bypass
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-low (state cleared on rising clk edge while rst==0)
- fu_valid_i  in  NUM_FU  per-channel result valid; nominally one-hot
- fu_data_i  in  NUM_FU*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
- rd_tag_i  in  TAG_W  destination tag of the current instruction
- wen_i  in  1  register-file write enable of the current instruction
- in_ready_o  out  1  stage can accept a result this cycle
- out_valid_o  out  1  result available to WB
- out_data_o  out  DATA_W  result
- out_tag_o  out  TAG_W  destination tag
- out_wen_o  out  1  write enable
- out_ready_i  in  1  WB accepts the result this cycle
- err_o  out  1  sticky multi-hot error flag

## Operation
- Input transfer (accept) occurs when |fu_valid_i && in_ready_o. Selection is by priority: the lowest set index wins. The payload is {tag, wen, data of winner}.
- Output transfer (drain) occurs when out_valid_o && out_ready_i.
- State: main entry M {v, data, tag, wen} and skid entry S {v, data, tag, wen}. The block moves between three states by occupancy:
  - EMPTY (M.v=0, S.v=0)
  - ONE (M.v=1, S.v=0)
  - FULL (M.v=1, S.v=1)
- in_ready_o = ~S.v, driven directly from a register with no combinational path from out_ready_i.
- Transitions:
  - EMPTY + accept (non-bypass) → ONE; M loaded.
  - ONE + accept + drain → ONE; M replaced by the new entry.
  - ONE + accept, no drain → FULL; new entry goes to S.
  - ONE + drain, no accept → EMPTY.
  - FULL + drain → ONE; S moves to M. No accept is possible, because in_ready_o=0.
- Bypass path, used only when BYPASS_CH ≥ 0, state is EMPTY, and the selected winner is BYPASS_CH:
  - out_valid_o=1 and out_* are driven combinationally from the inputs in the same cycle.
  - If out_ready_i=1, the result is consumed and the state stays EMPTY.
  - If out_ready_i=0, the result is captured into M and the state becomes ONE.
- When the bypass channel wins while M.v=1, it is treated like any other channel and follows normal ordering. Results never overtake one another: output order equals accept order.
- Data, tag and wen registers load only on capture. They are don't-care whenever the corresponding valid bit is 0, except after reset, where they are 0.

## Timing
- Reset values: out_valid_o=0, out_data_o=0, out_tag_o=0, out_wen_o=0, in_ready_o=1, err_o=0. M and S are both cleared.
- Reset mid-operation discards both entries, with no drain, on the clock edge where rst==0.
- Latency:
  - non-bypass channels: 1 cycle from accept to out_valid_o.
  - bypass channel in EMPTY: 0 cycles.
- Throughput: 1 result/cycle while out_ready_i=1.
- Backpressure: after one accept with no drain in ONE, in_ready_o falls on the next cycle. The upstream stage must hold fu_valid_i and payload while in_ready_o=0.
- fu_valid_i=0 has no effect: no state change and err_o is not updated.

## Configuration
- EX_RESULT_ONEHOT_CHK_EN defined:
  - On any accept cycle where fu_valid_i has more than one bit set, err_o is set on the next edge.
  - err_o stays set until reset.
  - Selection is still lowest-index priority.
- Not defined: err_o is constant 0 and no check logic is built.

## Test plan
- Basic path: NUM_FU=6, BYPASS_CH=4. Drive fu_valid_i=6'b000001, data0=0x11, tag=3, wen=1, out_ready_i=1. Required: out_valid_o=1 one cycle later with data 0x11, tag 3, wen 1.
- Bypass: in EMPTY, drive fu_valid_i=6'b010000, data4=0xDEAD_BEEF, out_ready_i=1. Required: same-cycle out_valid_o=1 and out_data_o=0xDEADBEEF; next cycle out_valid_o=0. Repeat with out_ready_i=0: required out_valid_o held at 0xDEADBEEF until ready.
- Backpressure: out_ready_i=0, accept 0xA then 0xB on back-to-back cycles. Required: in_ready_o=0 from the third cycle. Then release ready; required output 0xA then 0xB on consecutive cycles, and in_ready_o=1 after the first drain.
- Priority / err with macro: drive fu_valid_i=6'b001010 with data1=0x1, data3=0x3. Required: output 0x1 and err_o=1 from the next cycle until reset. Without the macro: err_o=0.
- Ordering: with M holding 0x5, send a bypass-channel result 0x6 while out_ready_i=1. Required: 0x5 is output before 0x6, with no same-cycle bypass.
- Reset in FULL: drive rst=0 for one cycle. Required: out_valid_o=0, in_ready_o=1, out_data_o=0 on the following cycle, and no stale entry appears afterward.

Source files
------------

// File: rtl/ex_result_if.sv
// Execute-result handshake bundle: FU result channels in, one selected result out to WB.
interface ex_result_if #(
  parameter int DATA_W = 32,
  parameter int NUM_FU = 6,
  parameter int TAG_W  = 5
);
  logic [NUM_FU-1:0]        fu_valid_i;
  logic [NUM_FU*DATA_W-1:0] fu_data_i;
  logic [TAG_W-1:0]         rd_tag_i;
  logic                     wen_i;
  logic                     in_ready_o;
  logic                     out_valid_o;
  logic [DATA_W-1:0]        out_data_o;
  logic [TAG_W-1:0]         out_tag_o;
  logic                     out_wen_o;
  logic                     out_ready_i;
  logic                     err_o;

  modport master (
    output fu_valid_i, fu_data_i, rd_tag_i, wen_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_tag_o, out_wen_o, err_o
  );
  modport slave (
    input  fu_valid_i, fu_data_i, rd_tag_i, wen_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_tag_o, out_wen_o, err_o
  );
endinterface

// File: rtl/ex_result_stage.sv
// EX result register: priority-select one FU channel into a main+skid buffer toward WB.
// Optional multi-hot check enabled by EX_RESULT_ONEHOT_CHK_EN (sticky err_o).
module ex_result_stage #(
  parameter int DATA_W    = 32,
  parameter int NUM_FU    = 6,
  parameter int TAG_W     = 5,
  parameter int BYPASS_CH = 4
) (
  input logic        clk,
  input logic        rst,
  ex_result_if.slave bus
);
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic              wen;
  } entry_t;

  localparam logic [NUM_FU-1:0] ONE_V = NUM_FU'(1);

  logic [NUM_FU-1:0] win_oh;
  logic              any_v, byp_hit, accept, drain, out_valid;
  entry_t            in_e, m_q, m_d, s_q, s_d;
  logic              m_v_q, m_v_d, s_v_q, s_v_d;

  // Isolate the lowest set bit: it is the priority winner.
  always_comb begin
    win_oh    = bus.fu_valid_i & (~bus.fu_valid_i + ONE_V);
    any_v     = |bus.fu_valid_i;
    in_e.data = '0;
    in_e.tag  = bus.rd_tag_i;
    in_e.wen  = bus.wen_i;
    for (int k = 0; k < NUM_FU; k++)
      if (win_oh[k]) in_e.data = in_e.data | bus.fu_data_i[k*DATA_W +: DATA_W];
  end

  // Bypass is only legal with an empty buffer, otherwise it would overtake M.
  generate
    if (BYPASS_CH >= 0 && BYPASS_CH < NUM_FU) begin : g_byp
      assign byp_hit = ~m_v_q & win_oh[BYPASS_CH];
    end else begin : g_nobyp
      assign byp_hit = 1'b0;
    end
  endgenerate

  assign out_valid       = m_v_q | byp_hit;
  assign accept          = any_v & ~s_v_q;
  assign drain           = out_valid & bus.out_ready_i;
  assign bus.in_ready_o  = ~s_v_q;
  assign bus.out_valid_o = out_valid;
  assign bus.out_data_o  = byp_hit ? in_e.data : m_q.data;
  assign bus.out_tag_o   = byp_hit ? in_e.tag  : m_q.tag;
  assign bus.out_wen_o   = byp_hit ? in_e.wen  : m_q.wen;

  always_comb begin
    m_d   = m_q;
    s_d   = s_q;
    m_v_d = m_v_q;
    s_v_d = s_v_q;
    if (s_v_q) begin
      if (drain) begin
        m_d   = s_q;
        s_v_d = 1'b0;
      end
    end else if (m_v_q) begin
      if (accept && drain) begin
        m_d = in_e;
      end else if (accept) begin
        s_d   = in_e;
        s_v_d = 1'b1;
      end else if (drain) begin
        m_v_d = 1'b0;
      end
    end else if (accept && !(byp_hit && bus.out_ready_i)) begin
      m_d   = in_e;
      m_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      m_q   <= '0;
      s_q   <= '0;
      m_v_q <= 1'b0;
      s_v_q <= 1'b0;
    end else begin
      m_q   <= m_d;
      s_q   <= s_d;
      m_v_q <= m_v_d;
      s_v_q <= s_v_d;
    end
  end

`ifdef EX_RESULT_ONEHOT_CHK_EN
  logic multi_v, err_q, err_d;
  assign multi_v = |(bus.fu_valid_i & ~win_oh);
  assign err_d   = err_q | (accept & multi_v);
  always_ff @(posedge clk) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end
  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif
endmodule

// File: tb/tb_ex_result_stage.sv
// Bench for ex_result_stage: directed vector table, corner sequences, random run vs queue model.
module tb_ex_result_stage;
  localparam int DW = 32, NF = 6, TW = 5, BCH = 4;
`ifdef EX_RESULT_ONEHOT_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk, rst;
  logic [DW-1:0] dch [NF];
  int total = 0, bad = 0;

  ex_result_if #(.DATA_W(DW), .NUM_FU(NF), .TAG_W(TW)) bus ();
  ex_result_stage #(.DATA_W(DW), .NUM_FU(NF), .TAG_W(TW), .BYPASS_CH(BCH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    bus.fu_data_i = '0;
    for (int k = 0; k < NF; k++) bus.fu_data_i[k*DW +: DW] = dch[k];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [NF-1:0] fv, input int ch, input logic [DW-1:0] d,
                       input logic [TW-1:0] tag, input logic wen, input logic rdy);
    for (int k = 0; k < NF; k++) dch[k] = 32'hBAD0_0000 | k;
    dch[ch] = d;
    bus.fu_valid_i  = fv;
    bus.rd_tag_i    = tag;
    bus.wen_i       = wen;
    bus.out_ready_i = rdy;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    edge1();
    rst = 1'b1;
  endtask

  typedef struct {
    logic [NF-1:0] fv;
    int            ch;
    logic [DW-1:0] d;
    logic [TW-1:0] tag;
    logic          wen, rdy;
    logic          e_ov, e_ir;
    logic [DW-1:0] e_od;
    logic [TW-1:0] e_tag;
    logic          e_wen;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    logic          wen;
  } pay_t;

  vec_t vt [19];
  pay_t q [$];

  initial begin
    vt[0]  = '{6'b000001, 0, 32'h11,        3, 1, 1, 0, 1, 0,            0, 0};
    vt[1]  = '{6'b000000, 0, 0,             0, 0, 1, 1, 1, 32'h11,       3, 1};
    vt[2]  = '{6'b000000, 0, 0,             0, 0, 1, 0, 1, 0,            0, 0};
    vt[3]  = '{6'b010000, 4, 32'hDEADBEEF,  7, 0, 1, 1, 1, 32'hDEADBEEF, 7, 0};
    vt[4]  = '{6'b000000, 0, 0,             0, 0, 1, 0, 1, 0,            0, 0};
    vt[5]  = '{6'b010000, 4, 32'hDEADBEEF,  9, 1, 0, 1, 1, 32'hDEADBEEF, 9, 1};
    vt[6]  = '{6'b000000, 0, 0,             0, 0, 0, 1, 1, 32'hDEADBEEF, 9, 1};
    vt[7]  = '{6'b000000, 0, 0,             0, 0, 1, 1, 1, 32'hDEADBEEF, 9, 1};
    vt[8]  = '{6'b000000, 0, 0,             0, 0, 0, 0, 1, 0,            0, 0};
    vt[9]  = '{6'b000100, 2, 32'hA,         1, 1, 0, 0, 1, 0,            0, 0};
    vt[10] = '{6'b001000, 3, 32'hB,         2, 0, 0, 1, 1, 32'hA,        1, 1};
    vt[11] = '{6'b000000, 0, 0,             0, 0, 0, 1, 0, 32'hA,        1, 1};
    vt[12] = '{6'b000000, 0, 0,             0, 0, 1, 1, 0, 32'hA,        1, 1};
    vt[13] = '{6'b000000, 0, 0,             0, 0, 1, 1, 1, 32'hB,        2, 0};
    vt[14] = '{6'b000000, 0, 0,             0, 0, 1, 0, 1, 0,            0, 0};
    vt[15] = '{6'b000001, 0, 32'h5,         4, 1, 0, 0, 1, 0,            0, 0};
    vt[16] = '{6'b010000, 4, 32'h6,         6, 1, 1, 1, 1, 32'h5,        4, 1};
    vt[17] = '{6'b000000, 0, 0,             0, 0, 1, 1, 1, 32'h6,        6, 1};
    vt[18] = '{6'b000000, 0, 0,             0, 0, 1, 0, 1, 0,            0, 0};

    drive('0, 0, 0, 0, 0, 0);
    do_reset();
    @(negedge clk);
    chk("rst ov",  bus.out_valid_o, 0);
    chk("rst od",  bus.out_data_o, 0);
    chk("rst tag", bus.out_tag_o, 0);
    chk("rst wen", bus.out_wen_o, 0);
    chk("rst ir",  bus.in_ready_o, 1);
    chk("rst err", bus.err_o, 0);
    edge1();

    for (int i = 0; i < 19; i++) begin
      drive(vt[i].fv, vt[i].ch, vt[i].d, vt[i].tag, vt[i].wen, vt[i].rdy);
      @(negedge clk);
      chk($sformatf("vec%0d ov", i), bus.out_valid_o, vt[i].e_ov);
      chk($sformatf("vec%0d ir", i), bus.in_ready_o, vt[i].e_ir);
      if (vt[i].e_ov) begin
        chk($sformatf("vec%0d od", i),  bus.out_data_o, vt[i].e_od);
        chk($sformatf("vec%0d tag", i), bus.out_tag_o, vt[i].e_tag);
        chk($sformatf("vec%0d wen", i), bus.out_wen_o, vt[i].e_wen);
      end
      edge1();
    end

    // multi-hot: lowest index wins, err follows the build option and is sticky
    drive(6'b001010, 1, 32'h1, 8, 1, 1);
    dch[3] = 32'h3;
    @(negedge clk);
    chk("prio ov0", bus.out_valid_o, 0);
    edge1();
    drive('0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("prio ov", bus.out_valid_o, 1);
    chk("prio od", bus.out_data_o, 32'h1);
    chk("prio err", bus.err_o, CHK);
    edge1();
    edge1();
    @(negedge clk);
    chk("err sticky", bus.err_o, CHK);
    do_reset();
    @(negedge clk);
    chk("err cleared", bus.err_o, 0);
    edge1();

    // reset while FULL drops both entries
    drive(6'b000001, 0, 32'h77, 1, 1, 0);
    edge1();
    drive(6'b000100, 2, 32'h88, 2, 1, 0);
    edge1();
    drive('0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("full ir", bus.in_ready_o, 0);
    do_reset();
    @(negedge clk);
    chk("frst ov",  bus.out_valid_o, 0);
    chk("frst ir",  bus.in_ready_o, 1);
    chk("frst od",  bus.out_data_o, 0);
    chk("frst tag", bus.out_tag_o, 0);
    chk("frst wen", bus.out_wen_o, 0);
    edge1();
    drive('0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("frst stale", bus.out_valid_o, 0);
      edge1();
    end

    // random traffic against an in-order queue model
    begin
      logic          err_m = 1'b0;
      logic [NF-1:0] fv;
      logic          rdy, e_ir, e_ov, acc, drn;
      pay_t          pin, e_out;
      int            win;
      q.delete();
      do_reset();
      for (int c = 0; c < 400; c++) begin
        case ($urandom_range(0, 9))
          0, 1, 2: fv = '0;
          3:       fv = NF'($urandom_range(1, (1 << NF) - 1));
          default: fv = NF'(1) << $urandom_range(0, NF - 1);
        endcase
        rdy = ($urandom_range(0, 9) < 6);
        for (int k = 0; k < NF; k++) dch[k] = $urandom;
        bus.fu_valid_i  = fv;
        bus.rd_tag_i    = TW'($urandom);
        bus.wen_i       = 1'($urandom);
        bus.out_ready_i = rdy;
        win = -1;
        for (int k = NF - 1; k >= 0; k--) if (fv[k]) win = k;
        pin.data = (win >= 0) ? dch[win] : '0;
        pin.tag  = bus.rd_tag_i;
        pin.wen  = bus.wen_i;
        e_ir  = (q.size() < 2);
        e_ov  = 1'b0;
        e_out = pin;
        if (q.size() > 0) begin
          e_ov  = 1'b1;
          e_out = q[0];
        end else if (win == BCH) begin
          e_ov = 1'b1;
        end
        acc = (fv != 0) && e_ir;
        drn = e_ov && rdy;
        @(negedge clk);
        chk("rnd ov",  bus.out_valid_o, e_ov);
        chk("rnd ir",  bus.in_ready_o, e_ir);
        chk("rnd err", bus.err_o, err_m);
        if (e_ov) begin
          chk("rnd od",  bus.out_data_o, e_out.data);
          chk("rnd tag", bus.out_tag_o, e_out.tag);
          chk("rnd wen", bus.out_wen_o, e_out.wen);
        end
        @(posedge clk);
        if (acc) q.push_back(pin);
        if (drn) void'(q.pop_front());
        if (CHK && acc && $countones(fv) > 1) err_m = 1'b1;
        #1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
